// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with buffered variable-latency
// load results into one registered register-file write per cycle.
module writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_waddr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_waddr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          alu_stall,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_din,
  output logic [$clog2(FIFO_DEPTH):0]   pend_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              alu_stall_q, alu_stall_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;

  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0]     ent_waddr [FIFO_DEPTH];
  logic [DATA_W-1:0]     ent_data  [FIFO_DEPTH];

  logic alu_sel, fifo_ne, mem_acc, load_live, pop, bypass, push, head_live;

  assign mem_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign pend_count = count_q;
  assign alu_stall  = alu_stall_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_din     = rf_din_q;

  // A load aimed at r0, or at the register the winning ALU result writes, is dead on arrival.
  always_comb begin
    alu_sel   = alu_valid && (alu_waddr != '0);
    fifo_ne   = (count_q != '0);
    mem_acc   = mem_valid && mem_ready;
    load_live = mem_acc && (mem_waddr != '0) && !(alu_sel && (mem_waddr == alu_waddr));
    pop       = !alu_sel && fifo_ne;
    bypass    = !alu_sel && !fifo_ne && load_live;
    push      = load_live && !bypass;
    head_live = ent_valid[rd_ptr_q];
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_din_d   = rf_din_q;
    if (alu_sel) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_waddr;
      rf_din_d   = alu_data;
    end else if (pop && head_live) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ent_waddr[rd_ptr_q];
      rf_din_d   = ent_data[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_waddr;
      rf_din_d   = mem_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Starvation counter saturates so a misbehaving upstream cannot wrap it back to zero.
  always_comb begin
    starve_d = starve_q;
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + SC_W'(1);
    end
    alu_stall_d = (starve_d == SC_W'(STARVE_LIMIT));
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
      logic              valid_q, valid_d;
      logic [ADDR_W-1:0] waddr_q, waddr_d;
      logic [DATA_W-1:0] data_q, data_d;

      // Killed entries keep their slot; only the valid flag drops.
      always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        if (alu_sel && (waddr_q == alu_waddr)) begin
          valid_d = 1'b0;
        end
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          valid_d = 1'b1;
          waddr_d = mem_waddr;
          data_d  = mem_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
        end
      end

      always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
      end

      assign ent_valid[gi] = valid_q;
      assign ent_waddr[gi] = waddr_q;
      assign ent_data[gi]  = data_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_din_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_din_q    <= rf_din_d;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_data;
  logic        alu_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_din;
  logic [1:0]  pend_count;

  int tests_run    = 0;
  int tests_failed = 0;

  writeback_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_data(mem_data),
    .alu_stall(alu_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of pending loads, each flagged live or killed.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        m_q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_din;
  int          m_starve;
  logic        m_stall;

  task automatic model_reset();
    m_q.delete();
    m_we     = 1'b0;
    m_waddr  = '0;
    m_din    = '0;
    m_starve = 0;
    m_stall  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit   alu_win, acc, nonempty, popped;
    ent_t e;
    alu_valid = av; alu_waddr = aa; alu_data = ad;
    mem_valid = mv; mem_waddr = ma; mem_data = md;
    alu_win  = av && (aa != 0);
    acc      = mv && (m_q.size() < DEPTH);
    nonempty = (m_q.size() != 0);
    popped   = 1'b0;
    m_we     = 1'b0;
    if (alu_win) begin
      m_we = 1'b1; m_waddr = aa; m_din = ad;
      foreach (m_q[i]) if (m_q[i].a == aa) m_q[i].live = 1'b0;
      if (acc && ma != 0 && ma != aa) m_q.push_back('{ma, md, 1'b1});
    end else if (nonempty) begin
      e = m_q.pop_front();
      popped = 1'b1;
      if (e.live) begin
        m_we = 1'b1; m_waddr = e.a; m_din = e.d;
      end
      if (acc && ma != 0) m_q.push_back('{ma, md, 1'b1});
    end else if (acc && ma != 0) begin
      m_we = 1'b1; m_waddr = ma; m_din = md;
    end
    if (nonempty && !popped) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
    m_stall = (m_starve == LIMIT);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    alu_valid = 0; alu_waddr = 0; alu_data = 0;
    mem_valid = 0; mem_waddr = 0; mem_data = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    tests_run++; if (rf_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
    tests_run++; if (rf_din !== 32'd0) begin tests_failed++; $display("FAIL reset_din: got %h expected 0", rf_din); end
    tests_run++; if (alu_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", alu_stall); end
    tests_run++; if (mem_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", mem_ready); end
    tests_run++; if (pend_count !== 2'd0) begin tests_failed++; $display("FAIL reset_pend: got %0d expected 0", pend_count); end
    rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_alu_basic();
    cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_din !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL alu_write: got we=%b a=%0d d=%h expected we=1 a=3 d=deadbeef", rf_we, rf_waddr, rf_din); end
    idle();
    tests_run++; if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_din !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL alu_hold: got we=%b a=%0d d=%h expected we=0 a=3 d=deadbeef", rf_we, rf_waddr, rf_din); end
    $display("[TB] alu write r3=deadbeef checked");
  endtask

  task automatic test_bypass();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_din !== 32'h12345678 || pend_count !== 2'd0) begin
      tests_failed++; $display("FAIL bypass: got we=%b a=%0d d=%h pend=%0d expected we=1 a=7 d=12345678 pend=0", rf_we, rf_waddr, rf_din, pend_count); end
    idle();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL bypass_after: got we=%b expected 0", rf_we); end
    $display("[TB] bypass load r7 checked");
  endtask

  task automatic test_starvation();
    cycle(1'b1, 5'd10, 32'h1, 1'b1, 5'd20, 32'hA0A0);
    tests_run++; if (pend_count !== 2'd1) begin tests_failed++; $display("FAIL starve_pend1: got %0d expected 1", pend_count); end
    cycle(1'b1, 5'd10, 32'h2, 1'b1, 5'd21, 32'hB1B1);
    tests_run++; if (pend_count !== 2'd2 || mem_ready !== 1'b0) begin
      tests_failed++; $display("FAIL starve_full: got pend=%0d ready=%b expected pend=2 ready=0", pend_count, mem_ready); end
    cycle(1'b1, 5'd10, 32'h3, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd10, 32'h4, 1'b0, 5'd0, 32'd0);
    tests_run++; if (alu_stall !== 1'b0) begin tests_failed++; $display("FAIL starve_early: got %b expected 0", alu_stall); end
    cycle(1'b1, 5'd10, 32'h5, 1'b0, 5'd0, 32'd0);
    tests_run++; if (alu_stall !== 1'b1) begin tests_failed++; $display("FAIL starve_stall: got %b expected 1", alu_stall); end
    idle();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_din !== 32'hA0A0 || pend_count !== 2'd1 || alu_stall !== 1'b0) begin
      tests_failed++; $display("FAIL starve_pop1: got we=%b a=%0d d=%h pend=%0d stall=%b expected we=1 a=20 d=a0a0 pend=1 stall=0",
                               rf_we, rf_waddr, rf_din, pend_count, alu_stall); end
    idle();
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd21 || rf_din !== 32'hB1B1 || pend_count !== 2'd0) begin
      tests_failed++; $display("FAIL starve_pop2: got we=%b a=%0d d=%h pend=%0d expected we=1 a=21 d=b1b1 pend=0", rf_we, rf_waddr, rf_din, pend_count); end
    $display("[TB] starvation stall and in-order drain checked");
  endtask

  task automatic test_waw_kill();
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h5555);
    cycle(1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd0, 32'd0);
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_din !== 32'hAAAA || pend_count !== 2'd1) begin
      tests_failed++; $display("FAIL waw_alu: got we=%b a=%0d d=%h pend=%0d expected we=1 a=5 d=aaaa pend=1", rf_we, rf_waddr, rf_din, pend_count); end
    idle();
    tests_run++; if (rf_we !== 1'b0 || rf_din !== 32'hAAAA || pend_count !== 2'd0) begin
      tests_failed++; $display("FAIL waw_silent_pop: got we=%b d=%h pend=%0d expected we=0 d=aaaa pend=0", rf_we, rf_din, pend_count); end
    cycle(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
    tests_run++; if (rf_din !== 32'h1 || pend_count !== 2'd0) begin
      tests_failed++; $display("FAIL waw_same_cycle: got d=%h pend=%0d expected d=1 pend=0", rf_din, pend_count); end
    idle();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL waw_discard: got we=%b expected 0", rf_we); end
    $display("[TB] WAW kill checked");
  endtask

  task automatic test_r0();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom);
      tests_run++; if (rf_we !== 1'b0 || pend_count !== 2'd0) begin
        tests_failed++; $display("FAIL r0_drop: got we=%b pend=%0d expected we=0 pend=0", rf_we, pend_count); end
    end
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    cycle(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_din !== 32'h99) begin
      tests_failed++; $display("FAIL r0_yield: got we=%b a=%0d d=%h expected we=1 a=9 d=99", rf_we, rf_waddr, rf_din); end
    idle();
    $display("[TB] r0 traffic checked");
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC);
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hD);
    tests_run++; if (pend_count !== 2'd2 || rf_we !== 1'b1) begin
      tests_failed++; $display("FAIL areset_pre: got pend=%0d we=%b expected pend=2 we=1", pend_count, rf_we); end
    alu_valid = 0; mem_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_din !== 32'd0 || pend_count !== 2'd0 || mem_ready !== 1'b1) begin
      tests_failed++; $display("FAIL areset_now: got we=%b a=%0d d=%h pend=%0d ready=%b expected all zero ready=1",
                               rf_we, rf_waddr, rf_din, pend_count, mem_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      tests_run++; if (rf_we !== 1'b0 || pend_count !== 2'd0 || mem_ready !== 1'b1) begin
        tests_failed++; $display("FAIL areset_stale: got we=%b pend=%0d ready=%b expected we=0 pend=0 ready=1", rf_we, pend_count, mem_ready); end
    end
    $display("[TB] async reset mid-operation checked");
  endtask

  task automatic test_random();
    logic       av, mv;
    logic [1:0] exp_pend;
    for (int n = 0; n < 500; n++) begin
      av = alu_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0);
      mv = ($urandom_range(0, 1) == 1);
      cycle(av, 5'($urandom_range(0, 7)), $urandom, mv, 5'($urandom_range(0, 7)), $urandom);
      exp_pend = 2'(m_q.size());
      tests_run++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_din !== m_din) begin
        tests_failed++; $display("FAIL rand_write[%0d]: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h",
                                 n, rf_we, rf_waddr, rf_din, m_we, m_waddr, m_din); end
      tests_run++; if (pend_count !== exp_pend || mem_ready !== (m_q.size() < DEPTH)) begin
        tests_failed++; $display("FAIL rand_fifo[%0d]: got pend=%0d ready=%b expected pend=%0d", n, pend_count, mem_ready, exp_pend); end
      tests_run++; if (alu_stall !== m_stall) begin
        tests_failed++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, alu_stall, m_stall); end
    end
    $display("[TB] randomized traffic: 500 cycles checked");
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_bypass();
    test_starvation();
    test_waw_kill();
    test_r0();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
